// File: rtl/stby_pwr_seq_pkg.sv
// Shared types and constants for the standby-well rail sequencer.
package stby_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAIT3V3  = 3'd1,
    ST_DLY      = 3'd2,
    ST_WAIT1V05 = 3'd3,
    ST_ON       = 3'd4,
    ST_SHDN     = 3'd5,
    ST_FAULT    = 3'd6
  } stby_state_e;

  localparam logic [1:0] FC_NONE      = 2'd0;
  localparam logic [1:0] FC_3V3_TO    = 2'd1;
  localparam logic [1:0] FC_1V05_TO   = 2'd2;
  localparam logic [1:0] FC_RAIL_LOST = 2'd3;

  localparam int unsigned t_stby_en_dly  = 4;
  localparam int unsigned t_stby_pg_to   = 20;
  localparam int unsigned t_stby_off_dly = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/stby_pwr_seq_pg_filter.sv
// Power-good conditioner: 2-flop synchronizer followed by a debounce filter.
// The filtered output flips only after DEBOUNCE_LEN consecutive synchronized
// samples that disagree with it, so raw-edge-to-output latency is 2+DEBOUNCE_LEN.
module stby_pwr_seq_pg_filter #(
  parameter int unsigned DEBOUNCE_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pg_raw,
  output logic pg_filt
);
  localparam int DCW = $clog2(DEBOUNCE_LEN + 1);

  logic [1:0]     sync_q, sync_d;
  logic [DCW-1:0] cnt_q, cnt_d;
  logic           filt_q, filt_d;

  // synchronizer shift and run-length count of disagreeing samples
  always_comb begin
    sync_d = {sync_q[0], pg_raw};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == DCW'(DEBOUNCE_LEN - 1)) filt_d = sync_q[1];
      else                                 cnt_d  = cnt_q + DCW'(1);
    end
  end

  // filter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign pg_filt = filt_q;

endmodule

// File: rtl/stby_pwr_seq.sv
// Standby-well rail sequencer: brings up 3.3 V then 1.05 V standby rails,
// supervises power-good with timeouts, shuts down in reverse order and
// latches a coded fault.
//
// state        | meaning
// ST_OFF       | both rails off, waiting for stby_go
// ST_WAIT3V3   | 3.3 V enabled, waiting for its PG (timeout -> code 1)
// ST_DLY       | 3.3 V good, delay before enabling 1.05 V
// ST_WAIT1V05  | 1.05 V enabled, waiting for its PG (timeout -> code 2)
// ST_ON        | both rails good, PG forwarded to ASW (rail loss -> code 3)
// ST_SHDN      | 1.05 V released, 3.3 V held for T_OFF_DLY
// ST_FAULT     | both rails off, wait for stby_go low
module stby_pwr_seq
  import stby_pwr_seq_pkg::*;
#(
  parameter int unsigned T_EN_DLY     = t_stby_en_dly,
  parameter int unsigned T_PG_TIMEOUT = t_stby_pg_to,
  parameter int unsigned T_OFF_DLY    = t_stby_off_dly,
  parameter int unsigned DEBOUNCE_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stby_go,
  input  logic       stbyP3v3_pwrgd_raw,
  input  logic       stbyP1v05_pwrgd_raw,
  output logic       stbyP3v3_en_n,
  output logic       stbyP1v05_en_n,
  output logic       stbyP1v05_pwrgd,
  output logic       fault_stby,
  output logic [1:0] fault_code,
  output logic [2:0] stby_fsm
);
  localparam int unsigned T_MAX = max3(T_PG_TIMEOUT, T_EN_DLY, T_OFF_DLY);
  localparam int CW = $clog2(T_MAX + 1);

  stby_state_e   state_q, state_d;
  logic [1:0]    cause_q, cause_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          tmr_tc;
  logic          pg3_f, pg1_f;

  logic          en3_n_q, en3_n_d;
  logic          en1_n_q, en1_n_d;
  logic          pwrgd_q, pwrgd_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;
  logic [2:0]    fsm_q, fsm_d;

  stby_pwr_seq_pg_filter #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_pg3 (
    .clk     (clk),
    .rst     (rst),
    .pg_raw  (stbyP3v3_pwrgd_raw),
    .pg_filt (pg3_f)
  );

  stby_pwr_seq_pg_filter #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_pg1 (
    .clk     (clk),
    .rst     (rst),
    .pg_raw  (stbyP1v05_pwrgd_raw),
    .pg_filt (pg1_f)
  );

  // down-counter reaches zero after the state's terminal count has elapsed
  assign tmr_tc = (tmr_q == '0);

  // next state and fault cause; timeouts lose to PG, faults beat stby_go
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_OFF: begin
        if (stby_go) begin
          state_d = ST_WAIT3V3;
          cause_d = FC_NONE;
        end
      end
      ST_WAIT3V3: begin
        if (tmr_tc && !pg3_f) begin
          state_d = ST_FAULT;
          cause_d = FC_3V3_TO;
        end else if (!stby_go) state_d = ST_OFF;
        else if (pg3_f)        state_d = ST_DLY;
      end
      ST_DLY: begin
        if (!stby_go)    state_d = ST_OFF;
        else if (tmr_tc) state_d = ST_WAIT1V05;
      end
      ST_WAIT1V05: begin
        if (tmr_tc && !pg1_f) begin
          state_d = ST_FAULT;
          cause_d = FC_1V05_TO;
        end else if (!stby_go) state_d = ST_SHDN;
        else if (pg1_f)        state_d = ST_ON;
      end
      ST_ON: begin
        if (!pg1_f || !pg3_f) begin
          state_d = ST_FAULT;
          cause_d = FC_RAIL_LOST;
        end else if (!stby_go) state_d = ST_SHDN;
      end
      ST_SHDN: begin
        if (tmr_tc) state_d = ST_OFF;
      end
      ST_FAULT: begin
        if (!stby_go) state_d = ST_OFF;
      end
      default: begin
        state_d = ST_FAULT;
        if (cause_q == FC_NONE) cause_d = FC_RAIL_LOST;
      end
    endcase
  end

  // shared timer: reload on every state change, count down in timed states
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_WAIT3V3, ST_WAIT1V05: tmr_d = CW'(T_PG_TIMEOUT - 1);
        ST_DLY:                  tmr_d = CW'(T_EN_DLY - 1);
        ST_SHDN:                 tmr_d = CW'(T_OFF_DLY - 1);
        default:                 tmr_d = '0;
      endcase
    end else if ((state_q inside {ST_WAIT3V3, ST_DLY, ST_WAIT1V05, ST_SHDN}) && !tmr_tc) begin
      tmr_d = tmr_q - CW'(1);
    end
  end

  // registered outputs decoded from the current state, one cycle behind it
  always_comb begin
    en3_n_d = !(state_q inside {ST_WAIT3V3, ST_DLY, ST_WAIT1V05, ST_ON, ST_SHDN});
    en1_n_d = !(state_q inside {ST_WAIT1V05, ST_ON});
    pwrgd_d = (state_q == ST_ON) && pg1_f;
    fault_d = (cause_q != FC_NONE);
    code_d  = cause_q;
    fsm_d   = state_q;
  end

  // state, timer and output registers; reset drops everything immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cause_q <= FC_NONE;
      tmr_q   <= '0;
      en3_n_q <= 1'b1;
      en1_n_q <= 1'b1;
      pwrgd_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      fsm_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      tmr_q   <= tmr_d;
      en3_n_q <= en3_n_d;
      en1_n_q <= en1_n_d;
      pwrgd_q <= pwrgd_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      fsm_q   <= fsm_d;
    end
  end

  assign stbyP3v3_en_n   = en3_n_q;
  assign stbyP1v05_en_n  = en1_n_q;
  assign stbyP1v05_pwrgd = pwrgd_q;
  assign fault_stby      = fault_q;
  assign fault_code      = code_q;
  assign stby_fsm        = fsm_q;

endmodule

// File: tb/tb_stby_pwr_seq.sv
// Scoreboard bench for stby_pwr_seq. Stimulus queues the expected sequence of
// output snapshots (with the cycle gap since the previous change, -1 = any);
// the monitor pops and compares whenever any output changes.
module tb_stby_pwr_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stby_go = 1'b0;
  logic       raw3 = 1'b0;
  logic       raw1 = 1'b0;
  logic       en3_n, en1_n, pwrgd, fault;
  logic [1:0] code;
  logic [2:0] fsm;
  logic [8:0] obs;

  typedef struct {
    logic [8:0] v;
    int         dt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  stby_pwr_seq #(
    .T_EN_DLY    (4),
    .T_PG_TIMEOUT(20),
    .T_OFF_DLY   (3),
    .DEBOUNCE_LEN(3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stby_go            (stby_go),
    .stbyP3v3_pwrgd_raw (raw3),
    .stbyP1v05_pwrgd_raw(raw1),
    .stbyP3v3_en_n      (en3_n),
    .stbyP1v05_en_n     (en1_n),
    .stbyP1v05_pwrgd    (pwrgd),
    .fault_stby         (fault),
    .fault_code         (code),
    .stby_fsm           (fsm)
  );

  assign obs = {fsm, en3_n, en1_n, pwrgd, fault, code};

  function automatic logic [8:0] pk(input int f, input bit e3, input bit e1,
                                    input bit pg, input bit flt, input int c);
    return {f[2:0], e3, e1, pg, flt, c[1:0]};
  endfunction

  task automatic push(input logic [8:0] v, input int dt);
    exp_t e;
    e.v  = v;
    e.dt = dt;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [8:0] got, input int dt);
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("FAIL unexpected_change: got fsm=%0d en3_n=%b en1_n=%b pg=%b fault=%b code=%0d dt=%0d, want no change",
               got[8:6], got[5], got[4], got[3], got[2], got[1:0], dt);
    end else begin
      e = sb_q.pop_front();
      if (got !== e.v || (e.dt >= 0 && dt != e.dt)) begin
        n_miss++;
        $display("FAIL vec%0d: got fsm=%0d en3_n=%b en1_n=%b pg=%b fault=%b code=%0d dt=%0d, want fsm=%0d en3_n=%b en1_n=%b pg=%b fault=%b code=%0d dt=%0d",
                 n_vec, got[8:6], got[5], got[4], got[3], got[2], got[1:0], dt,
                 e.v[8:6], e.v[5], e.v[4], e.v[3], e.v[2], e.v[1:0], e.dt);
      end
    end
  endtask

  // monitor: first snapshot after reset, then every output change
  initial begin
    logic [8:0] prev;
    int         cyc;
    @(negedge clk);
    while (rst) @(negedge clk);
    check(obs, -1);
    prev = obs;
    cyc  = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (obs !== prev) begin
        check(obs, cyc);
        prev = obs;
        cyc  = 0;
      end
    end
  end

  // stimulus
  initial begin
    push(pk(0, 1, 1, 0, 0, 0), -1);
    tick(3);
    rst = 1'b0;
    tick(3);

    // nominal bring-up
    push(pk(1, 0, 1, 0, 0, 0), -1);
    push(pk(2, 0, 1, 0, 0, 0), 10);
    push(pk(3, 0, 0, 0, 0, 0), 4);
    push(pk(4, 0, 0, 1, 0, 0), 2);
    stby_go = 1'b1;
    tick(5);  raw3 = 1'b1;
    tick(6);  raw1 = 1'b1;
    tick(15);

    // 2-cycle PG1 glitch is filtered, 3-cycle drop faults with code 3
    raw1 = 1'b0; tick(2); raw1 = 1'b1;
    tick(8);
    push(pk(4, 0, 0, 0, 0, 0), -1);
    push(pk(6, 1, 1, 0, 1, 3), 1);
    raw1 = 1'b0; tick(3); raw1 = 1'b1;
    tick(8);
    push(pk(0, 1, 1, 0, 1, 3), -1);
    stby_go = 1'b0;
    tick(4);

    // restart clears fault, then orderly shutdown
    push(pk(1, 0, 1, 0, 0, 0), -1);
    push(pk(2, 0, 1, 0, 0, 0), 1);
    push(pk(3, 0, 0, 0, 0, 0), 4);
    push(pk(4, 0, 0, 1, 0, 0), 1);
    push(pk(5, 0, 1, 0, 0, 0), -1);
    push(pk(0, 1, 1, 0, 0, 0), 3);
    stby_go = 1'b1;
    tick(12);
    stby_go = 1'b0;
    tick(6);

    // 3.3 V timeout
    raw3 = 1'b0; raw1 = 1'b0;
    tick(8);
    push(pk(1, 0, 1, 0, 0, 0), -1);
    push(pk(6, 1, 1, 0, 1, 1), 20);
    stby_go = 1'b1;
    tick(25);
    push(pk(0, 1, 1, 0, 1, 1), -1);
    stby_go = 1'b0;
    tick(4);

    // 1.05 V timeout
    raw3 = 1'b1;
    tick(8);
    push(pk(1, 0, 1, 0, 0, 0), -1);
    push(pk(2, 0, 1, 0, 0, 0), 1);
    push(pk(3, 0, 0, 0, 0, 0), 4);
    push(pk(6, 1, 1, 0, 1, 2), 20);
    stby_go = 1'b1;
    tick(30);
    push(pk(0, 1, 1, 0, 1, 2), -1);
    stby_go = 1'b0;
    tick(4);

    // PG1 qualifies in the timeout cycle: PG wins
    push(pk(1, 0, 1, 0, 0, 0), -1);
    push(pk(2, 0, 1, 0, 0, 0), 1);
    push(pk(3, 0, 0, 0, 0, 0), 4);
    push(pk(4, 0, 0, 1, 0, 0), 20);
    stby_go = 1'b1;
    tick(20);
    raw1 = 1'b1;
    tick(10);

    // stby_go falls in the cycle PG3 is lost: fault wins
    push(pk(6, 1, 1, 0, 1, 3), -1);
    push(pk(0, 1, 1, 0, 1, 3), 1);
    raw3 = 1'b0;
    tick(5);
    stby_go = 1'b0;
    tick(6);

    // reset in ST_DLY, then clean restart
    raw3 = 1'b1;
    tick(8);
    push(pk(1, 0, 1, 0, 0, 0), -1);
    push(pk(2, 0, 1, 0, 0, 0), 1);
    push(pk(0, 1, 1, 0, 0, 0), 2);
    stby_go = 1'b1;
    tick(4);
    rst = 1'b1; stby_go = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(8);
    push(pk(1, 0, 1, 0, 0, 0), -1);
    push(pk(2, 0, 1, 0, 0, 0), 1);
    push(pk(3, 0, 0, 0, 0, 0), 4);
    push(pk(4, 0, 0, 1, 0, 0), 1);
    push(pk(5, 0, 1, 0, 0, 0), -1);
    push(pk(0, 1, 1, 0, 0, 0), 3);
    stby_go = 1'b1;
    tick(12);
    stby_go = 1'b0;
    tick(8);

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL drain: got %0d expected changes never seen, want 0", sb_q.size());
      n_vec  += sb_q.size();
      n_miss += sb_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
